// File: rtl/jalr_pred_pkg.sv
// Shared types and saturating-confidence helpers for the JALR target buffer.
package jalr_pred_pkg;

   typedef logic [1:0] conf_t;

   localparam conf_t CONF_MAX  = 2'd3;
   localparam conf_t CONF_INIT = 2'd1;

   function automatic conf_t sat_inc(input conf_t c);
      return (c == CONF_MAX) ? c : conf_t'(c + 2'd1);
   endfunction

   function automatic conf_t sat_dec(input conf_t c);
      return (c == 2'd0) ? c : conf_t'(c - 2'd1);
   endfunction

endpackage

// File: rtl/jtb_entry_next.sv
// Next-state rule for one JALR target buffer entry given a resolved jump.
module jtb_entry_next
   import jalr_pred_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int TAG_BITS   = 8
) (
   input  logic                  entry_valid_i,
   input  logic [TAG_BITS-1:0]   entry_tag_i,
   input  logic [ADDR_WIDTH-1:0] entry_target_i,
   input  conf_t                 entry_conf_i,
   input  logic                  hit_i,
   input  logic                  mispred_i,
   input  logic [TAG_BITS-1:0]   new_tag_i,
   input  logic [ADDR_WIDTH-1:0] new_target_i,
   output logic                  next_valid_o,
   output logic [TAG_BITS-1:0]   next_tag_o,
   output logic [ADDR_WIDTH-1:0] next_target_o,
   output conf_t                 next_conf_o
);

   // Hysteresis: a stable entry must be worn down to zero before it is replaced.
   always_comb begin
      next_valid_o  = entry_valid_i;
      next_tag_o    = entry_tag_i;
      next_target_o = entry_target_i;
      next_conf_o   = entry_conf_i;
      if (hit_i) begin
         if (!mispred_i) begin
            next_conf_o = sat_inc(entry_conf_i);
         end else if (entry_conf_i == 2'd0) begin
            next_target_o = new_target_i;
            next_conf_o   = CONF_INIT;
         end else begin
            next_conf_o = sat_dec(entry_conf_i);
         end
      end else if (!entry_valid_i || entry_conf_i == 2'd0) begin
         next_valid_o  = 1'b1;
         next_tag_o    = new_tag_i;
         next_target_o = new_target_i;
         next_conf_o   = CONF_INIT;
      end else begin
         next_conf_o = sat_dec(entry_conf_i);
      end
   end

endmodule

// File: rtl/jalr_target_buffer.sv
// Tagged, confidence-filtered indirect-jump target predictor: multi-lane lookup,
// multi-port training with youngest-port-wins on index collisions.
module jalr_target_buffer
   import jalr_pred_pkg::*;
#(
   parameter int          ADDR_WIDTH  = 32,
   parameter int          ENTRIES     = 16,
   parameter int          TAG_BITS    = 8,
   parameter int          NUM_LANES   = 5,
   parameter int          NUM_UPD     = 3,
   parameter logic [1:0]  CONF_THRESH = 2'd1,
   localparam int         LANE_BITS   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 flush_i,
   input  logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] current_pc_i,
   input  logic [NUM_LANES-1:0]                 is_jalr_i,
   output logic                                 pred_valid_o,
   output logic [ADDR_WIDTH-1:0]                pred_target_o,
   output logic [LANE_BITS-1:0]                 pred_lane_o,
   input  logic [NUM_UPD-1:0]                   upd_valid_i,
   input  logic [NUM_UPD-1:0][ADDR_WIDTH-1:0]   upd_link_pc_i,
   input  logic [NUM_UPD-1:0]                   upd_mispred_i,
   input  logic [NUM_UPD-1:0][ADDR_WIDTH-1:0]   upd_target_i
);

   localparam int INDEX_BITS = $clog2(ENTRIES);
   localparam int TAG_LSB    = INDEX_BITS + 2;

   typedef struct packed {
      logic                  valid;
      logic [TAG_BITS-1:0]   tag;
      logic [ADDR_WIDTH-1:0] target;
      conf_t                 conf;
   } jtb_entry_t;

   jtb_entry_t table_q [ENTRIES];
   jtb_entry_t table_d [ENTRIES];

   logic                    lane_found;
   logic [LANE_BITS-1:0]    sel_lane;
   logic [ADDR_WIDTH-1:0]   sel_pc;
   logic [INDEX_BITS-1:0]   lk_idx;
   logic [TAG_BITS-1:0]     lk_tag;
   jtb_entry_t              lk_entry;
   logic                    lk_hit;

   logic [NUM_UPD-1:0][ADDR_WIDTH-1:0] jalr_pc;
   logic [INDEX_BITS-1:0]   upd_idx   [NUM_UPD];
   logic [TAG_BITS-1:0]     upd_tag   [NUM_UPD];
   jtb_entry_t              cur_entry [NUM_UPD];
   jtb_entry_t              nxt_entry [NUM_UPD];
   logic [NUM_UPD-1:0]      upd_hit;
   logic [NUM_UPD-1:0]      port_act;
   logic                    unused_pc_bits;

   // Oldest JALR lane owns the prediction, hit or not.
   always_comb begin
      lane_found = 1'b0;
      sel_lane   = '0;
      sel_pc     = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
         if (!lane_found && is_jalr_i[l]) begin
            lane_found = 1'b1;
            sel_lane   = LANE_BITS'(l);
            sel_pc     = current_pc_i[l];
         end
      end
   end

   always_comb begin
      lk_idx        = sel_pc[INDEX_BITS+1:2];
      lk_tag        = sel_pc[TAG_LSB+TAG_BITS-1:TAG_LSB];
      lk_entry      = table_q[lk_idx];
      lk_hit        = lane_found && lk_entry.valid && (lk_entry.tag == lk_tag)
                      && (lk_entry.conf >= CONF_THRESH);
      pred_valid_o  = lk_hit;
      pred_target_o = lk_hit ? lk_entry.target : '0;
      pred_lane_o   = sel_lane;
   end

   always_comb begin
      for (int p = 0; p < NUM_UPD; p++) begin
         jalr_pc[p]   = upd_link_pc_i[p] - ADDR_WIDTH'(4);
         upd_idx[p]   = jalr_pc[p][INDEX_BITS+1:2];
         upd_tag[p]   = jalr_pc[p][TAG_LSB+TAG_BITS-1:TAG_LSB];
         cur_entry[p] = table_q[upd_idx[p]];
         upd_hit[p]   = cur_entry[p].valid && (cur_entry[p].tag == upd_tag[p]);
      end
   end

   assign unused_pc_bits = ^{sel_pc, jalr_pc};

   for (genvar p = 0; p < NUM_UPD; p++) begin : g_upd
      logic                  nv;
      logic [TAG_BITS-1:0]   nt;
      logic [ADDR_WIDTH-1:0] ntg;
      conf_t                 nc;

      jtb_entry_next #(
         .ADDR_WIDTH (ADDR_WIDTH),
         .TAG_BITS   (TAG_BITS)
      ) u_next (
         .entry_valid_i  (cur_entry[p].valid),
         .entry_tag_i    (cur_entry[p].tag),
         .entry_target_i (cur_entry[p].target),
         .entry_conf_i   (cur_entry[p].conf),
         .hit_i          (upd_hit[p]),
         .mispred_i      (upd_mispred_i[p]),
         .new_tag_i      (upd_tag[p]),
         .new_target_i   (upd_target_i[p]),
         .next_valid_o   (nv),
         .next_tag_o     (nt),
         .next_target_o  (ntg),
         .next_conf_o    (nc)
      );

      assign nxt_entry[p] = {nv, nt, ntg, nc};
   end

   // A port is dropped when a younger (higher-numbered) port targets the same index.
   always_comb begin
      for (int p = 0; p < NUM_UPD; p++) begin
         port_act[p] = upd_valid_i[p];
         for (int q = p + 1; q < NUM_UPD; q++) begin
            if (upd_valid_i[q] && (upd_idx[q] == upd_idx[p])) begin
               port_act[p] = 1'b0;
            end
         end
      end
   end

   always_comb begin
      table_d = table_q;
      for (int p = 0; p < NUM_UPD; p++) begin
         if (port_act[p]) begin
            table_d[upd_idx[p]] = nxt_entry[p];
         end
      end
      if (flush_i) begin
         for (int e = 0; e < ENTRIES; e++) begin
            table_d[e].valid = 1'b0;
            table_d[e].conf  = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int e = 0; e < ENTRIES; e++) begin
            table_q[e] <= '0;
         end
      end else begin
         table_q <= table_d;
      end
   end

endmodule

// File: tb/tb_jalr_target_buffer.sv
// Scoreboard bench for jalr_target_buffer: directed lookups/updates, hand-derived expectations.
module tb_jalr_target_buffer;

   logic                clk;
   logic                reset;
   logic                flush_i;
   logic [4:0][31:0]    current_pc_i;
   logic [4:0]          is_jalr_i;
   logic                pred_valid_o;
   logic [31:0]         pred_target_o;
   logic [2:0]          pred_lane_o;
   logic [2:0]          upd_valid_i;
   logic [2:0][31:0]    upd_link_pc_i;
   logic [2:0]          upd_mispred_i;
   logic [2:0][31:0]    upd_target_i;

   int   checkCount = 0;
   int   errorCount = 0;
   logic chkReq     = 1'b0;

   logic        expValidQ  [$];
   logic [31:0] expTargetQ [$];
   logic [2:0]  expLaneQ   [$];
   string       expNameQ   [$];

   jalr_target_buffer #(
      .ADDR_WIDTH  (32),
      .ENTRIES     (16),
      .TAG_BITS    (8),
      .NUM_LANES   (5),
      .NUM_UPD     (3),
      .CONF_THRESH (2'd1)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .flush_i       (flush_i),
      .current_pc_i  (current_pc_i),
      .is_jalr_i     (is_jalr_i),
      .pred_valid_o  (pred_valid_o),
      .pred_target_o (pred_target_o),
      .pred_lane_o   (pred_lane_o),
      .upd_valid_i   (upd_valid_i),
      .upd_link_pc_i (upd_link_pc_i),
      .upd_mispred_i (upd_mispred_i),
      .upd_target_i  (upd_target_i)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Monitor: pops one expected prediction whenever the driver marks a lookup cycle.
   always @(negedge clk) begin : monitor
      logic        ev;
      logic [31:0] et;
      logic [2:0]  el;
      string       nm;
      if (chkReq) begin
         checkCount++;
         if (expValidQ.size() == 0) begin
            errorCount++;
            $display("[TB] FAIL scoreboard_underflow: lookup seen with no expected entry");
         end else begin
            ev = expValidQ.pop_front();
            et = expTargetQ.pop_front();
            el = expLaneQ.pop_front();
            nm = expNameQ.pop_front();
            if (pred_valid_o !== ev || pred_target_o !== et || pred_lane_o !== el) begin
               errorCount++;
               $display("[TB] FAIL %s: got valid=%0b target=%h lane=%0d, expected valid=%0b target=%h lane=%0d",
                        nm, pred_valid_o, pred_target_o, pred_lane_o, ev, et, el);
            end
         end
      end
   end

   task automatic clearInputs();
      flush_i       = 1'b0;
      is_jalr_i     = '0;
      upd_valid_i   = '0;
      upd_mispred_i = '0;
      chkReq        = 1'b0;
      for (int l = 0; l < 5; l++) current_pc_i[l] = '0;
      for (int p = 0; p < 3; p++) begin
         upd_link_pc_i[p] = '0;
         upd_target_i[p]  = '0;
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
      clearInputs();
   endtask

   task automatic setUpdate(input int port, input logic [31:0] link, input logic mp,
                            input logic [31:0] tgt);
      upd_valid_i[port]   = 1'b1;
      upd_link_pc_i[port] = link;
      upd_mispred_i[port] = mp;
      upd_target_i[port]  = tgt;
   endtask

   task automatic applyStimulus(input int lane, input logic [4:0] jalr, input logic [31:0] pc);
      current_pc_i[lane] = pc;
      is_jalr_i          = jalr;
   endtask

   task automatic checkOutput(input string name, input logic v, input logic [31:0] t,
                              input logic [2:0] l);
      expValidQ.push_back(v);
      expTargetQ.push_back(t);
      expLaneQ.push_back(l);
      expNameQ.push_back(name);
      chkReq = 1'b1;
   endtask

   // pc 0x100: idx 0 tag 0x04; pc 0x500: idx 0 tag 0x14; 0x108 idx 2; 0x110 idx 4; 0x118 idx 6.
   initial begin
      reset = 1'b0;
      clearInputs();
      nextCycle();
      nextCycle();
      reset = 1'b1;

      applyStimulus(2, 5'b00100, 32'h100);
      checkOutput("reset_state", 1'b0, 32'h0, 3'd2);

      nextCycle();
      setUpdate(0, 32'h104, 1'b1, 32'h2000);
      applyStimulus(1, 5'b00010, 32'h100);
      checkOutput("no_bypass", 1'b0, 32'h0, 3'd1);
      nextCycle();
      applyStimulus(1, 5'b00010, 32'h100);
      checkOutput("alloc_hit", 1'b1, 32'h2000, 3'd1);

      nextCycle();
      setUpdate(0, 32'h504, 1'b1, 32'h3000);
      applyStimulus(0, 5'b00001, 32'h500);
      checkOutput("tag_mismatch", 1'b0, 32'h0, 3'd0);
      nextCycle();
      setUpdate(0, 32'h504, 1'b1, 32'h3000);
      applyStimulus(0, 5'b00001, 32'h100);
      checkOutput("aged_conf0", 1'b0, 32'h0, 3'd0);
      nextCycle();
      applyStimulus(3, 5'b01000, 32'h500);
      checkOutput("realloc_hit", 1'b1, 32'h3000, 3'd3);
      nextCycle();
      applyStimulus(0, 5'b00001, 32'h100);
      checkOutput("evicted_old", 1'b0, 32'h0, 3'd0);

      // Re-install 0x100, train past saturation, then wear it down with mispredicts.
      nextCycle(); setUpdate(0, 32'h104, 1'b1, 32'h2000);
      applyStimulus(4, 5'b10000, 32'h100); checkOutput("train_age", 1'b0, 32'h0, 3'd4);
      nextCycle(); setUpdate(0, 32'h104, 1'b1, 32'h2000);
      applyStimulus(4, 5'b10000, 32'h100); checkOutput("train_alloc", 1'b0, 32'h0, 3'd4);
      nextCycle(); setUpdate(1, 32'h104, 1'b0, 32'h2000);
      applyStimulus(4, 5'b10000, 32'h100); checkOutput("train_c1", 1'b1, 32'h2000, 3'd4);
      nextCycle(); setUpdate(1, 32'h104, 1'b0, 32'h2000);
      applyStimulus(4, 5'b10000, 32'h100); checkOutput("train_c2", 1'b1, 32'h2000, 3'd4);
      nextCycle(); setUpdate(1, 32'h104, 1'b0, 32'h2000);
      applyStimulus(4, 5'b10000, 32'h100); checkOutput("train_c3", 1'b1, 32'h2000, 3'd4);
      nextCycle(); setUpdate(2, 32'h104, 1'b1, 32'h4000);
      applyStimulus(4, 5'b10000, 32'h100); checkOutput("sat_c3", 1'b1, 32'h2000, 3'd4);
      nextCycle(); setUpdate(2, 32'h104, 1'b1, 32'h4000);
      applyStimulus(4, 5'b10000, 32'h100); checkOutput("mp1_c2", 1'b1, 32'h2000, 3'd4);
      nextCycle(); setUpdate(2, 32'h104, 1'b1, 32'h4000);
      applyStimulus(4, 5'b10000, 32'h100); checkOutput("mp2_c1", 1'b1, 32'h2000, 3'd4);
      nextCycle(); setUpdate(2, 32'h104, 1'b1, 32'h4000);
      applyStimulus(4, 5'b10000, 32'h100); checkOutput("mp3_c0", 1'b0, 32'h0, 3'd4);
      nextCycle();
      applyStimulus(4, 5'b10000, 32'h100); checkOutput("mp4_retarget", 1'b1, 32'h4000, 3'd4);

      // Same-cycle collision on idx 2 plus an independent port on idx 4.
      nextCycle();
      setUpdate(0, 32'h10C, 1'b1, 32'hA000);
      setUpdate(2, 32'h10C, 1'b1, 32'hB000);
      setUpdate(1, 32'h114, 1'b1, 32'hC000);
      applyStimulus(0, 5'b00001, 32'h108);
      checkOutput("collide_pre", 1'b0, 32'h0, 3'd0);
      nextCycle();
      applyStimulus(2, 5'b00100, 32'h108);
      checkOutput("youngest_wins", 1'b1, 32'hB000, 3'd2);
      nextCycle();
      applyStimulus(1, 5'b11010, 32'h110);
      current_pc_i[3] = 32'h108;
      checkOutput("parallel_port_lowlane", 1'b1, 32'hC000, 3'd1);

      nextCycle();
      flush_i = 1'b1;
      setUpdate(1, 32'h11C, 1'b1, 32'hD000);
      applyStimulus(0, 5'b00001, 32'h110);
      checkOutput("pre_flush", 1'b1, 32'hC000, 3'd0);
      nextCycle();
      applyStimulus(0, 5'b00001, 32'h110);
      checkOutput("flush_idx4", 1'b0, 32'h0, 3'd0);
      nextCycle();
      applyStimulus(1, 5'b00010, 32'h118);
      checkOutput("flush_beats_upd", 1'b0, 32'h0, 3'd1);
      nextCycle();
      applyStimulus(2, 5'b00100, 32'h108);
      checkOutput("flush_idx2", 1'b0, 32'h0, 3'd2);

      nextCycle();
      setUpdate(0, 32'h104, 1'b1, 32'h2000);
      nextCycle();
      applyStimulus(0, 5'b00001, 32'h100);
      checkOutput("pre_reset_hit", 1'b1, 32'h2000, 3'd0);
      nextCycle();
      setUpdate(0, 32'h104, 1'b0, 32'h2000);
      applyStimulus(0, 5'b00001, 32'h100);
      #2;
      reset = 1'b0;
      checkOutput("reset_async", 1'b0, 32'h0, 3'd0);
      nextCycle();
      reset = 1'b1;
      applyStimulus(0, 5'b00001, 32'h100);
      checkOutput("reset_cleared", 1'b0, 32'h0, 3'd0);
      nextCycle();
      applyStimulus(0, 5'b00000, 32'h100);
      checkOutput("no_jalr", 1'b0, 32'h0, 3'd0);

      nextCycle();
      checkCount++;
      if (expValidQ.size() != 0) begin
         errorCount++;
         $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", expValidQ.size());
      end
      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
